// File: rtl/mem_bridge.sv
// mem_bridge: turns single-cycle CPU memory strobes into a req/ack bus
// cycle with wait states, stall back to the CPU, timeout and sticky error.
module mem_bridge #(
   parameter logic [15:0] TIMEOUT  = 16'd255,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        err,
   input  logic        err_clr,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   input  logic        bus_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [31:0] r_rdata;
   logic        r_err;
   logic        r_bus_req;
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [31:0] r_bus_wdata;

   logic w_start;
   logic w_illegal;
   logic w_tmo;

   assign w_illegal = mem_rd & mem_wr;
   assign w_start   = mem_rd ^ mem_wr;
   assign w_tmo     = (TIMEOUT != 16'd0) && (r_cnt == TIMEOUT - 16'd1);

   assign stall     = ((r_state == S_IDLE) && (mem_rd || mem_wr))
                    || (r_state == S_BUSY);
   assign rdata     = r_rdata;
   assign err       = r_err;
   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 16'd0;
         r_rdata     <= 32'd0;
         r_err       <= 1'b0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= 32'd0;
         r_bus_wdata <= 32'd0;
      end else begin
         // a set later in this block overrides the clear
         if (err_clr)
            r_err <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_illegal) begin
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end else if (w_start) begin
                  r_bus_addr  <= addr;
                  r_bus_wdata <= wdata;
                  r_bus_we    <= mem_wr;
                  r_cnt       <= 16'd0;
                  r_bus_req   <= 1'b1;
                  r_state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (bus_err || (!bus_ack && w_tmo)) begin
                  r_err     <= 1'b1;
                  if (!r_bus_we)
                     r_rdata <= ERR_DATA;
                  r_bus_req <= 1'b0;
                  r_state   <= S_DONE;
               end else if (bus_ack) begin
                  if (!r_bus_we)
                     r_rdata <= bus_rdata;
                  r_bus_req <= 1'b0;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state   <= S_IDLE;
               r_bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed and random transactions against a
// transaction-level model of the bridge (expected rdata, err, req count).
module tb_mem_bridge;

   localparam logic [15:0] TMO  = 16'd4;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_rd = 1'b0;
   logic        mem_wr = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        stall;
   logic        err;
   logic        err_clr = 1'b0;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata = 32'd0;
   logic        bus_ack = 1'b0;
   logic        bus_err = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_rdata = 32'd0;
   logic        m_err = 1'b0;
   bit          after_done = 1'b0;

   mem_bridge #(
      .TIMEOUT  (TMO),
      .ERR_DATA (ERRD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall     (stall),
      .err       (err),
      .err_clr   (err_clr),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   // ackcyc: bus_req cycle (1-based) carrying the ack, 0 = slave never answers
   task automatic run_txn(input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input int ackcyc, input bit berr,
                          input logic [31:0] rdat);
      int n;
      int exp_n;
      bit legal;
      bit done;
      legal = rd ^ wr;
      exp_n = !legal ? 0 : (ackcyc == 0 ? int'(TMO) : ackcyc);
      mem_rd = rd;
      mem_wr = wr;
      addr   = a;
      wdata  = d;
      if (after_done) begin
         bus_ack = 1'b1;
         bus_err = 1'b1;
         @(negedge clk);
         bus_ack = 1'b0;
         bus_err = 1'b0;
         check("idle_no_req", bus_req, 0);
      end else begin
         #1;
      end
      check("stall_idle", stall, 1);
      n = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (bus_req) begin
            n++;
            check("bus_addr", bus_addr, a);
            check("bus_we", bus_we, wr);
            check("bus_wdata", bus_wdata, d);
            check("stall_busy", stall, 1);
            bus_rdata = $urandom;
            bus_ack = (n == ackcyc);
            bus_err = berr && (n == ackcyc);
            if (n == ackcyc)
               bus_rdata = rdat;
         end else begin
            done = 1'b1;
            bus_ack = 1'b0;
            bus_err = 1'b0;
            if (!legal) begin
               m_err = 1'b1;
            end else if (ackcyc == 0 || berr) begin
               m_err = 1'b1;
               if (rd)
                  m_rdata = ERRD;
            end else if (rd) begin
               m_rdata = rdat;
            end
            check("n_req", n, exp_n);
            check("stall_done", stall, 0);
            check("rdata", rdata, m_rdata);
            check("err", err, m_err);
            mem_rd = 1'b0;
            mem_wr = 1'b0;
         end
      end
      check("txn_done", done, 1);
      if (!done) begin
         mem_rd = 1'b0;
         mem_wr = 1'b0;
      end
      after_done = 1'b1;
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_err = 1'b0;
      check("err_clr", err, 0);
      after_done = 1'b0;
   endtask

   initial begin
      #1;
      check("rst_req", bus_req, 0);
      check("rst_rdata", rdata, 0);
      check("rst_err", err, 0);
      check("rst_addr", bus_addr, 0);
      check("rst_stall", stall, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      run_txn(1, 0, 32'h10, 32'h0, 3, 0, 32'hCAFE_F00D);
      run_txn(0, 1, 32'h20, 32'h1234_5678, 1, 0, 32'h0);
      run_txn(1, 0, 32'h30, 32'h0, 0, 0, 32'h0);
      clear_err();
      run_txn(1, 0, 32'h40, 32'h0, 4, 0, 32'h0BAD_CAFE);
      run_txn(1, 0, 32'h44, 32'h0, 2, 1, 32'h1111_1111);
      clear_err();
      run_txn(0, 1, 32'h48, 32'hA5A5_5A5A, 0, 0, 32'h0);
      clear_err();

      run_txn(1, 1, 32'h50, 32'h0, 0, 0, 32'h0);
      @(negedge clk);
      check("ill_idle_req", bus_req, 0);
      check("ill_idle_stall", stall, 0);
      after_done = 1'b0;
      clear_err();

      err_clr = 1'b1;
      run_txn(1, 1, 32'h54, 32'h0, 0, 0, 32'h0);
      err_clr = 1'b0;
      clear_err();

      mem_rd = 1'b1;
      addr = 32'h10;
      repeat (2) @(negedge clk);
      check("pre_rst_req", bus_req, 1);
      rst = 1'b0;
      #1;
      m_rdata = 32'd0;
      m_err = 1'b0;
      check("mid_rst_req", bus_req, 0);
      check("mid_rst_stall", stall, 1);
      check("mid_rst_addr", bus_addr, 0);
      check("mid_rst_rdata", rdata, 0);
      mem_rd = 1'b0;
      #1;
      check("mid_rst_idle", stall, 0);
      @(negedge clk);
      rst = 1'b1;
      after_done = 1'b0;
      run_txn(1, 0, 32'h10, 32'h0, 2, 0, 32'h5555_AAAA);

      for (int i = 0; i < 40; i++) begin
         int op;
         op = $urandom_range(0, 9);
         run_txn(op == 0 || op <= 5, op == 0 || op >= 6,
                 $urandom, $urandom, $urandom_range(0, 4),
                 $urandom_range(0, 7) == 0, $urandom);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            after_done = 1'b0;
         end
         if ($urandom_range(0, 4) == 0)
            clear_err();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Downstream of the control unit's memory strobes.
- Converts the CU's single-cycle mem_rd/mem_wr requests into a request/acknowledge transaction on an external memory bus with variable wait states.
- Asserts stall back to the CPU until the transaction completes, and registers read data.
- Provides a bus timeout and a sticky error flag so a dead slave cannot hang the CPU.

Parameters:
- TIMEOUT, 16'd255: max cycles bus_req may wait for bus_ack before abort; 0 disables the timeout.
- ERR_DATA, 32'h00000000: value loaded into rdata on an aborted/errored read.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-low.
- mem_rd  in  1  CPU read request, level, held while stall=1.
- mem_wr  in  1  CPU write request, level, held while stall=1.
- addr  in  32  CPU address.
- wdata  in  32  CPU write data.
- rdata  out  32  registered read data.
- stall  out  1  CPU must hold its state while high.
- err  out  1  sticky bus error/timeout flag.
- err_clr  in  1  clears err (synchronous).
- bus_req  out  1  bus transaction request.
- bus_we  out  1  1=write, 0=read; valid with bus_req.
- bus_addr  out  32  bus address.
- bus_wdata  out  32  bus write data.
- bus_rdata  in  32  bus read data, valid with bus_ack.
- bus_ack  in  1  slave completion, one cycle.
- bus_err  in  1  slave error, one cycle; takes priority over bus_ack.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; rdata=0, err=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, timeout counter=0.
  - Applies immediately mid-transaction: bus_req drops in the same cycle.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If mem_rd xor mem_wr: latch addr to bus_addr, wdata to bus_wdata, mem_wr to bus_we; counter=0; next state BUSY.
  - If mem_rd and mem_wr are both high (illegal): set err, no bus cycle, next state DONE.
- BUSY:
  - bus_req=1; bus_addr, bus_wdata and bus_we are held stable.
  - bus_err=1: set err; rdata=ERR_DATA if read; go to DONE.
  - Else bus_ack=1: if read, rdata<=bus_rdata; go to DONE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: set err; rdata=ERR_DATA if read; go to DONE.
  - Else counter++.
- DONE:
  - bus_req=0; stall=0, so the CPU advances at this edge.
  - Request inputs are ignored during DONE because they still carry the completed access.
  - Next state IDLE.
- stall (combinational) = (IDLE and (mem_rd or mem_wr)) or BUSY.
- bus_req is a registered output, high exactly while state==BUSY.
- Latency, with request first seen in IDLE at cycle 0:
  - bus_req high at cycles 1..N, where the ack arrives in cycle N.
  - DONE at cycle N+1: rdata valid, stall=0.
  - Minimum access is 3 cycles (N=1).
- Back-to-back: a new request can start in the IDLE cycle after DONE; there is no bubble beyond DONE.
- rdata holds its value until the next completed read, and is unchanged by writes.
- err:
  - Set on bus_err, timeout, or illegal request.
  - Cleared by err_clr in any state.
  - If set and clear happen in the same cycle, set wins.
- bus_ack or bus_err outside BUSY is ignored.

Test Plan:
- Read, 2 wait states: mem_rd=1, addr=32'h0000_0010; ack at the 3rd bus_req cycle with bus_rdata=32'hCAFE_F00D -> bus_req high 3 cycles with bus_we=0 and bus_addr=32'h10; DONE on the next cycle with rdata=32'hCAFEF00D, stall=0; stall high for the 4 cycles before.
- Write, zero wait: mem_wr=1, addr=32'h20, wdata=32'h1234_5678; ack on the 1st bus_req cycle -> bus_we=1, bus_wdata=32'h12345678; total 3 cycles; rdata unchanged.
- Timeout: TIMEOUT=4, read, bus_ack never asserted -> bus_req high exactly 4 cycles, then err=1, rdata=ERR_DATA, stall=0 in DONE; err_clr pulse -> err=0.
- Bus error vs ack: bus_err=1 and bus_ack=1 in the same cycle on a read -> err=1, rdata=ERR_DATA.
- Illegal request: mem_rd=mem_wr=1 -> no bus_req; err=1 next cycle; DONE then IDLE.
- Reset mid-transfer: rst=0 during BUSY -> bus_req=0 immediately; after release, state=IDLE and stall follows the inputs; a subsequent read of 32'h10 completes normally.
